serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 101 ++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the width of the bit counter that walks through the operand.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must reach WIDTH-1; a floor of one bit keeps degenerate widths legal.
  function automatic int cntWidth(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell computing a - b - bi. It is built from the same
// XOR/AND/OR structure as the team's full-adder cell.
module full_subtractor (
  output logic o_d,
  output logic o_bo,
  input  logic i_a,
  input  logic i_b,
  input  logic i_bi
);

  logic w_axb;

  // A borrow comes out when b beats a outright, or when they tie and a borrow comes in.
  always_comb begin
    w_axb = i_a ^ i_b;
    o_d   = w_axb ^ i_bi;
    o_bo  = (~i_a & i_b) | (~w_axb & i_bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor that computes d = a - b LSB first through one
// full_subtractor cell, and uses a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_d,
  output logic             o_bout
);

  localparam int CW = cntWidth(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic             w_x;
  logic             w_brNext;
  logic             w_last;

  full_subtractor u_cell (
    .o_d  (w_x),
    .o_bo (w_brNext),
    .i_a  (r_sa[0]),
    .i_b  (r_sb[0]),
    .i_bi (r_br)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // DONE accepts start exactly like IDLE, which allows back-to-back operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_sa    <= i_a;
            r_sb    <= i_b;
            r_d     <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_d   <= {w_x, r_d[WIDTH-1:1]};
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_br  <= w_brNext;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_bout  <= w_brNext;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_d    = r_d;
  assign o_bout = r_bout;

endmodule
